// File: rtl/pl_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pl_hazard_unit_pkg
// Description : Shared operand-forwarding select encodings and a priority
//               helper for the 5-stage RV32I hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pl_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // The younger producer in MEM always holds the newer value, so it wins.
    function automatic fwd_sel_e fwd_prio(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pl_hazard_unit_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : pl_fwd_sel
// Description : Per-operand forwarding comparator and MEM-over-WB priority mux.
// Revision    : 1.0 - initial release
// ============================================================================
module pl_fwd_sel
    import pl_hazard_unit_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_we,
    output logic [1:0]      sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hardwired to zero, so a write to it never produces a value to forward.
    assign w_mem_hit = mem_we && (mem_rd != '0) && (mem_rd == src);
    assign w_wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == src);
    assign sel       = fwd_prio(w_mem_hit, w_wb_hit);

endmodule
`default_nettype wire

// File: rtl/pl_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pl_hazard_unit
// Description : Forwarding selects, load-use/RAW interlock, redirect flush,
//               data-memory wait-state stalls and saturating event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pl_hazard_unit
    import pl_hazard_unit_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int MEM_WAIT = 0,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  ID_rs1,
    input  logic [RA_W-1:0]  ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [RA_W-1:0]  EX_rs1,
    input  logic [RA_W-1:0]  EX_rs2,
    input  logic [RA_W-1:0]  EX_rd,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [RA_W-1:0]  MEM_rd,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic [RA_W-1:0]  WB_rd,
    input  logic             WB_RegWrite,
    input  logic             redirect,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             bubble_EX,
    output logic             bubble_WB,
    output logic             flush_ID,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mw_state_e;

    // The counter holds MEM_WAIT-2 at most: the IDLE and final WAIT cycles supply the other two stalls.
    localparam int                 c_cnt_w    = (MEM_WAIT > 2) ? $clog2(MEM_WAIT - 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = (MEM_WAIT > 1) ? c_cnt_w'(MEM_WAIT - 2) : '0;

    mw_state_e          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic       w_access;
    logic       w_mem_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] w_fwd_a_en;
    logic [1:0] w_fwd_b_en;
    logic       w_ex_wr;
    logic       w_mem_wr;
    logic       w_hit_rs1;
    logic       w_hit_rs2;
    logic       w_load_use;
    logic       w_raw_ex;
    logic       w_raw_mem;
    logic       w_interlock;

    pl_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .src    (EX_rs1),
        .mem_rd (MEM_rd),
        .mem_we (MEM_RegWrite),
        .wb_rd  (WB_rd),
        .wb_we  (WB_RegWrite),
        .sel    (w_fwd_a)
    );

    pl_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .src    (EX_rs2),
        .mem_rd (MEM_rd),
        .mem_we (MEM_RegWrite),
        .wb_rd  (WB_rd),
        .wb_we  (WB_RegWrite),
        .sel    (w_fwd_b)
    );

    generate
        if (FWD_EN != 0) begin : g_fwd_on
            assign w_fwd_a_en = w_fwd_a;
            assign w_fwd_b_en = w_fwd_b;
        end else begin : g_fwd_off
            assign w_fwd_a_en = FWD_RF;
            assign w_fwd_b_en = FWD_RF;
        end
    endgenerate

    assign w_access  = MEM_MemRead || MEM_MemWrite;
    assign w_ex_wr   = EX_RegWrite  && (EX_rd  != '0);
    assign w_mem_wr  = MEM_RegWrite && (MEM_rd != '0);
    assign w_hit_rs1 = ID_use_rs1 && (ID_rs1 == EX_rd);
    assign w_hit_rs2 = ID_use_rs2 && (ID_rs2 == EX_rd);

    assign w_load_use = EX_MemRead && (EX_rd != '0) && (w_hit_rs1 || w_hit_rs2);
    assign w_raw_ex   = w_ex_wr && (w_hit_rs1 || w_hit_rs2);
    assign w_raw_mem  = w_mem_wr && ((ID_use_rs1 && (ID_rs1 == MEM_rd)) ||
                                     (ID_use_rs2 && (ID_rs2 == MEM_rd)));
    assign w_interlock = w_load_use || ((FWD_EN == 0) && (w_raw_ex || w_raw_mem));

    always_comb begin
        w_mem_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_mem_stall = (MEM_WAIT > 0) && w_access;
            S_WAIT:  w_mem_stall = 1'b1;
            default: w_mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((MEM_WAIT > 0) && w_access) begin
                        if (MEM_WAIT > 1) begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_cnt_init;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0)
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory stall dominates; a held redirect then lands in the DONE cycle.
    always_comb begin
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        stall_EX  = 1'b0;
        stall_MEM = 1'b0;
        bubble_EX = 1'b0;
        bubble_WB = 1'b0;
        flush_ID  = 1'b0;
        fwdA      = FWD_RF;
        fwdB      = FWD_RF;
        busy      = 1'b0;
        if (!reset) begin
            fwdA = w_fwd_a_en;
            fwdB = w_fwd_b_en;
            busy = (r_state != S_IDLE);
            if (w_mem_stall) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                stall_EX  = 1'b1;
                stall_MEM = 1'b1;
                bubble_WB = 1'b1;
            end else if (redirect) begin
                flush_ID  = 1'b1;
                bubble_EX = 1'b1;
            end else if (w_interlock) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                bubble_EX = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_IF && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_ID && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pl_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pl_hazard_unit
// Description : Three differently parameterised hazard units on shared inputs,
//               checked every cycle against a countdown-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pl_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
    logic       ID_use_rs1, ID_use_rs2, EX_RegWrite, EX_MemRead;
    logic       MEM_RegWrite, MEM_MemRead, MEM_MemWrite, WB_RegWrite, redirect;

    always #5 clk = ~clk;

    // Observed outputs per instance: {stall_IF,stall_ID,stall_EX,stall_MEM,bubble_EX,bubble_WB,flush_ID,busy}
    logic [7:0]  flags_o [3];
    logic [3:0]  fwd_o   [3];
    logic [63:0] scnt_o  [3];
    logic [63:0] fcnt_o  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 0) ? 4 : 32;
        localparam int MW = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
        localparam int FE = (g == 2) ? 0 : 1;
        logic s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_id, bsy;
        logic [1:0]    fa, fb;
        logic [CW-1:0] sc, fc;

        pl_hazard_unit #(.RA_W(5), .MEM_WAIT(MW), .FWD_EN(FE), .CNT_W(CW)) u_dut (
            .clk(clk), .reset(reset),
            .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
            .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
            .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
            .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite),
            .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
            .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite), .redirect(redirect),
            .stall_IF(s_if), .stall_ID(s_id), .stall_EX(s_ex), .stall_MEM(s_mem),
            .bubble_EX(b_ex), .bubble_WB(b_wb), .flush_ID(f_id),
            .fwdA(fa), .fwdB(fb), .busy(bsy), .stall_cnt(sc), .flush_cnt(fc)
        );

        assign flags_o[g] = {s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_id, bsy};
        assign fwd_o[g]   = {fa, fb};
        assign scnt_o[g]  = 64'(sc);
        assign fcnt_o[g]  = 64'(fc);
    end

    int     n_tests = 0;
    int     n_fail  = 0;
    int     mw_k   [3] = '{0, 3, 2};
    bit     fe_k   [3] = '{1'b1, 1'b1, 1'b0};
    longint cmax_k [3] = '{64'd15, 64'hFFFF_FFFF, 64'hFFFF_FFFF};

    // Reference state: stall cycles still owed, a one-cycle "finishing" flag, counters.
    int     rem  [3];
    bit     fin  [3];
    longint scnt [3];
    longint fcnt [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input int k, input logic [4:0] src);
        if (!fe_k[k])                                          return 2'b00;
        if (MEM_RegWrite && MEM_rd != 0 && MEM_rd == src)      return 2'b01;
        if (WB_RegWrite && WB_rd != 0 && WB_rd == src)         return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit reads(input logic [4:0] r);
        return (ID_use_rs1 && ID_rs1 == r) || (ID_use_rs2 && ID_rs2 == r);
    endfunction

    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) begin
            bit         ms, bsy, lu, raw;
            logic [7:0] ef;
            logic [3:0] efwd;
            ms  = (rem[k] > 0) || (!fin[k] && (MEM_MemRead || MEM_MemWrite) && mw_k[k] > 0);
            bsy = (rem[k] > 0) || fin[k];
            lu  = EX_MemRead && EX_rd != 0 && reads(EX_rd);
            raw = !fe_k[k] && ((EX_RegWrite && EX_rd != 0 && reads(EX_rd)) ||
                               (MEM_RegWrite && MEM_rd != 0 && reads(MEM_rd)));
            if (reset)            ef = 8'h00;
            else if (ms)          ef = 8'b1111_0100;
            else if (redirect)    ef = 8'b0000_1010;
            else if (lu || raw)   ef = 8'b1100_1000;
            else                  ef = 8'h00;
            if (!reset) ef[0] = bsy;
            efwd = reset ? 4'b0 : {fwd_ref(k, EX_rs1), fwd_ref(k, EX_rs2)};

            check($sformatf("flags[%0d]", k), 64'(flags_o[k]), 64'(ef));
            check($sformatf("fwd[%0d]", k),   64'(fwd_o[k]),   64'(efwd));
            check($sformatf("stall_cnt[%0d]", k), scnt_o[k], scnt[k]);
            check($sformatf("flush_cnt[%0d]", k), fcnt_o[k], fcnt[k]);

            if (reset) begin
                rem[k] = 0; fin[k] = 0; scnt[k] = 0; fcnt[k] = 0;
            end else begin
                if (ef[7] && scnt[k] < cmax_k[k]) scnt[k]++;
                if (ef[1] && fcnt[k] < cmax_k[k]) fcnt[k]++;
                if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) fin[k] = 1;
                end else if (fin[k]) begin
                    fin[k] = 0;
                end else if ((MEM_MemRead || MEM_MemWrite) && mw_k[k] > 0) begin
                    rem[k] = mw_k[k] - 1;
                    if (rem[k] == 0) fin[k] = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd} = '0;
        {ID_use_rs1, ID_use_rs2, EX_RegWrite, EX_MemRead} = '0;
        {MEM_RegWrite, MEM_MemRead, MEM_MemWrite, WB_RegWrite, redirect} = '0;
    endtask

    task automatic set_load_use();
        EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 5'd7; ID_rs2 = 5'd7; ID_use_rs2 = 1;
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0; fin[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
        clear_inputs();
        reset = 1;
        @(negedge clk);
        step(); step();
        reset = 0;

        // Forwarding: MEM hit, MEM over WB, x0 never forwarded
        MEM_rd = 5; MEM_RegWrite = 1; EX_rs1 = 5; step();
        WB_rd = 5; WB_RegWrite = 1; step();
        MEM_rd = 0; EX_rs1 = 0; WB_rd = 0; step();

        clear_inputs(); set_load_use(); step();
        clear_inputs(); step();

        clear_inputs(); set_load_use(); redirect = 1; step();
        clear_inputs(); step();

        // Store held in MEM through its wait states
        clear_inputs(); MEM_MemWrite = 1;
        repeat (4) step();
        clear_inputs(); repeat (3) step();

        // Load with a redirect held in EX across the wait
        MEM_MemRead = 1; redirect = 1;
        repeat (4) step();
        clear_inputs(); repeat (3) step();

        // RAW without forwarding: EX match, then the producer moves to MEM
        EX_rd = 3; EX_RegWrite = 1; ID_rs1 = 3; ID_use_rs1 = 1; step();
        EX_rd = 0; EX_RegWrite = 0; MEM_rd = 3; MEM_RegWrite = 1; step();
        clear_inputs(); step();

        // Reset in the middle of a wait
        MEM_MemWrite = 1; step(); step();
        reset = 1; step();
        reset = 0; clear_inputs(); step(); step();

        // Long stall run drives the 4-bit counter into saturation
        set_load_use(); repeat (20) step();
        redirect = 1; repeat (18) step();
        clear_inputs(); step();

        for (int i = 0; i < 600; i++) begin
            reset        = pct(2);
            ID_rs1       = 5'($urandom_range(0, 3));
            ID_rs2       = 5'($urandom_range(0, 3));
            ID_use_rs1   = pct(60);
            ID_use_rs2   = pct(60);
            EX_rs1       = 5'($urandom_range(0, 3));
            EX_rs2       = 5'($urandom_range(0, 3));
            EX_rd        = 5'($urandom_range(0, 3));
            EX_RegWrite  = pct(50);
            EX_MemRead   = pct(25);
            MEM_rd       = 5'($urandom_range(0, 3));
            MEM_RegWrite = pct(50);
            MEM_MemRead  = pct(12);
            MEM_MemWrite = pct(8);
            WB_rd        = 5'($urandom_range(0, 3));
            WB_RegWrite  = pct(50);
            redirect     = pct(15);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
